// File: rtl/conv_input_sequencer.sv
// Frame sequencer between three show-ahead channel FIFOs and the 3x3 window engine.
// Streams WIDTH*HEIGHT tagged pixels, then WIDTH+2 zero flush beats, then pulses done.
module conv_input_sequencer #(
    parameter int DWIDTH = 8,
    parameter int WIDTH  = 56,
    parameter int HEIGHT = 56,
    parameter int CW     = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic [DWIDTH-1:0] fifo_data_0,
    input  logic [DWIDTH-1:0] fifo_data_1,
    input  logic [DWIDTH-1:0] fifo_data_2,
    output logic              fifo_rdreq,
    output logic [DWIDTH-1:0] out_data_0,
    output logic [DWIDTH-1:0] out_data_1,
    output logic [DWIDTH-1:0] out_data_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_flush,
    output logic [CW-1:0]     out_col,
    output logic [CW-1:0]     out_row,
    output logic              busy,
    output logic              done
);

    localparam int FLUSH_BEATS = WIDTH + 2;
    localparam int FW          = $clog2(FLUSH_BEATS + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST  = CW'(HEIGHT - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FLUSH_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [CW-1:0]   row_reg, row_next;
    logic [FW-1:0]   fcnt_reg, fcnt_next;
    logic            valid_reg, valid_next;
    logic            flush_reg, flush_next;
    logic [CW-1:0]   tag_col_reg, tag_col_next;
    logic [CW-1:0]   tag_row_reg, tag_row_next;
    logic            done_reg, done_next;

    logic            load_en;
    logic            pop;
    logic            zero_load;
    logic [2:0]      fifo_empty;
    logic [3*DWIDTH-1:0] fifo_data_all;

    assign fifo_empty    = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign fifo_data_all = {fifo_data_2, fifo_data_1, fifo_data_0};

    // A held beat may only be replaced once the engine has taken it.
    assign load_en = !valid_reg || out_ready;

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        fcnt_next    = fcnt_reg;
        valid_next   = valid_reg;
        flush_next   = flush_reg;
        tag_col_next = tag_col_reg;
        tag_row_next = tag_row_reg;
        done_next    = 1'b0;
        pop          = 1'b0;
        zero_load    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    col_next   = '0;
                    row_next   = '0;
                    fcnt_next  = '0;
                end
            end

            STREAM: begin
                if (load_en) begin
                    if (fifo_empty == 3'b000) begin
                        pop          = 1'b1;
                        valid_next   = 1'b1;
                        flush_next   = 1'b0;
                        tag_col_next = col_reg;
                        tag_row_next = row_reg;
                        if (col_reg == COL_LAST) begin
                            col_next = '0;
                            if (row_reg == ROW_LAST) begin
                                row_next   = '0;
                                state_next = FLUSH;
                            end else begin
                                row_next = row_reg + CW'(1);
                            end
                        end else begin
                            col_next = col_reg + CW'(1);
                        end
                    end else begin
                        valid_next = 1'b0;
                    end
                end
            end

            FLUSH: begin
                if (load_en) begin
                    zero_load    = 1'b1;
                    valid_next   = 1'b1;
                    flush_next   = 1'b1;
                    tag_col_next = '0;
                    tag_row_next = '0;
                    fcnt_next    = fcnt_reg + FW'(1);
                    if (fcnt_reg == FCNT_LAST) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (valid_reg && out_ready) begin
                    valid_next = 1'b0;
                    flush_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything, including a start or a completing frame.
        if (abort) begin
            state_next = IDLE;
            valid_next = 1'b0;
            flush_next = 1'b0;
            col_next   = '0;
            row_next   = '0;
            fcnt_next  = '0;
            done_next  = 1'b0;
            pop        = 1'b0;
            zero_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            fcnt_reg    <= '0;
            valid_reg   <= 1'b0;
            flush_reg   <= 1'b0;
            tag_col_reg <= '0;
            tag_row_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            fcnt_reg    <= fcnt_next;
            valid_reg   <= valid_next;
            flush_reg   <= flush_next;
            tag_col_reg <= tag_col_next;
            tag_row_reg <= tag_row_next;
            done_reg    <= done_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [DWIDTH-1:0] data_reg;
            logic [DWIDTH-1:0] data_next;

            always_comb begin
                data_next = data_reg;
                if (pop) begin
                    data_next = fifo_data_all[gi*DWIDTH +: DWIDTH];
                end else if (zero_load) begin
                    data_next = '0;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    data_reg <= '0;
                end else begin
                    data_reg <= data_next;
                end
            end
        end
    endgenerate

    assign out_data_0 = g_chan[0].data_reg;
    assign out_data_1 = g_chan[1].data_reg;
    assign out_data_2 = g_chan[2].data_reg;

    assign fifo_rdreq = pop;
    assign out_valid  = valid_reg;
    assign out_flush  = flush_reg;
    assign out_col    = tag_col_reg;
    assign out_row    = tag_row_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule
